// File: rtl/aes256_key_schedule_pkg.sv
// aes256_key_schedule_pkg: shared AES constants, S-box table and key-schedule state type.
// No ports. Byte 0 of every key or word sits in the least significant bits.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH
`define AES256_KEY_LENGTH 256
`define AES_BLOCK_SIZE 128
`define AES_WORD_SIZE 32
`define AES_1ST_WORD 31:0
`define AES_2ND_WORD 63:32
`define AES_3RD_WORD 95:64
`define AES_4TH_WORD 127:96
`define AES_5TH_WORD 159:128
`define AES_6TH_WORD 191:160
`define AES_7TH_WORD 223:192
`define AES_8TH_WORD 255:224
`define AES_RCON_01 32'h00000001
`define AES_RCON_02 32'h00000002
`define AES_RCON_03 32'h00000004
`define AES_RCON_04 32'h00000008
`define AES_RCON_05 32'h00000010
`define AES_RCON_06 32'h00000020
`define AES_RCON_07 32'h00000040
`endif

package aes256_key_schedule_pkg;
    localparam int KEY_W = `AES256_KEY_LENGTH;
    localparam int BLK_W = `AES_BLOCK_SIZE;
    localparam int WORD_W = `AES_WORD_SIZE;
    localparam int AES256_NUM_ROUND_KEYS = 15;
    typedef enum logic [1:0] {IDLE, EXPAND, LOADED, STREAM} key_sched_state_t;
    // Entry n is selected by rcon index n; entry 0 is never used.
    localparam logic [7:0][WORD_W-1:0] AES_RCON = {`AES_RCON_07, `AES_RCON_06, `AES_RCON_05,
        `AES_RCON_04, `AES_RCON_03, `AES_RCON_02, `AES_RCON_01, 32'h0};
    // Element 0 occupies the most significant byte, so AES_SBOX[x] is S(x).
    localparam logic [0:255][7:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16};
endpackage

// File: rtl/aes256_key_expansion_step.sv
// aes256_key_expansion_step: one combinational AES-256 key-expansion step.
// Ports: Input_key = 256-bit window {rk[r-1], rk[r-2]}, Round = r (2..14),
//        Output_key = rk[r]. Also holds the byte S-box used by the step.
module aes_sbox
    import aes256_key_schedule_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    assign out_o = AES_SBOX[in_i];
endmodule

module aes256_key_expansion_step
    import aes256_key_schedule_pkg::*;
(
    input  logic [KEY_W-1:0]  Input_key,
    input  logic [3:0]        Round,
    output logic [BLK_W-1:0]  Output_key
);
    logic [WORD_W-1:0] w8, sub_in, sub_out, temp;
    assign w8 = Input_key[`AES_8TH_WORD];
    // Byte 0 is in the low bits, so RotWord is a right rotate by one byte here.
    assign sub_in = Round[0] ? w8 : {w8[7:0], w8[31:8]};
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.in_i(sub_in[8*i+:8]), .out_o(sub_out[8*i+:8]));
    end
    assign temp = Round[0] ? sub_out : sub_out ^ AES_RCON[Round[3:1]];
    assign Output_key[`AES_1ST_WORD] = Input_key[`AES_1ST_WORD] ^ temp;
    assign Output_key[`AES_2ND_WORD] = Input_key[`AES_2ND_WORD] ^ Output_key[`AES_1ST_WORD];
    assign Output_key[`AES_3RD_WORD] = Input_key[`AES_3RD_WORD] ^ Output_key[`AES_2ND_WORD];
    assign Output_key[`AES_4TH_WORD] = Input_key[`AES_4TH_WORD] ^ Output_key[`AES_3RD_WORD];
endmodule

// File: rtl/aes256_key_schedule.sv
// aes256_key_schedule: iterative AES-256 key expansion into a 15-entry round-key buffer,
// streamed forward or reverse over valid/ready.
// Ports: Clk/Rst (sync, active high); Key_valid/Key_ready/Key accept a cipher key;
//        Expanded flags a complete schedule; Stream_start/Stream_reverse request a stream;
//        Rk_valid/Rk_ready/Rk_data/Rk_index/Rk_last present round keys.
module aes256_key_schedule
    import aes256_key_schedule_pkg::*;
#(
    parameter int NUM_ROUNDS = 14
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Key_valid,
    output logic             Key_ready,
    input  logic [KEY_W-1:0] Key,
    output logic             Expanded,
    input  logic             Stream_start,
    input  logic             Stream_reverse,
    output logic             Rk_valid,
    input  logic             Rk_ready,
    output logic [BLK_W-1:0] Rk_data,
    output logic [3:0]       Rk_index,
    output logic             Rk_last
);
    if (NUM_ROUNDS != 14) begin : g_bad_rounds
        $error("aes256_key_schedule supports only NUM_ROUNDS = 14");
    end
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
    key_sched_state_t state_q, state_d;
    logic [KEY_W-1:0] win_q, win_d;
    // Round counter while expanding, stream index while streaming.
    logic [3:0] idx_q, idx_d;
    logic rev_q, rev_d;
    logic [BLK_W-1:0] buf_q [AES256_NUM_ROUND_KEYS];
    logic [BLK_W-1:0] step_key;
    logic key_hs;
    aes256_key_expansion_step u_step (.Input_key(win_q), .Round(idx_q), .Output_key(step_key));
    assign Key_ready = (state_q == IDLE) || (state_q == LOADED);
    assign Expanded = (state_q == LOADED) || (state_q == STREAM);
    assign Rk_valid = (state_q == STREAM);
    assign Rk_index = Rk_valid ? idx_q : 4'd0;
    assign Rk_data = Rk_valid ? buf_q[idx_q] : '0;
    assign Rk_last = Rk_valid && (rev_q ? idx_q == 4'd0 : idx_q == LAST_IDX);
    assign key_hs = Key_valid && Key_ready;
    always_comb begin
        state_d = state_q;
        win_d = win_q;
        idx_d = idx_q;
        rev_d = rev_q;
        unique case (state_q)
            IDLE, LOADED: begin
                // A key handshake wins over a simultaneous stream request.
                if (key_hs) begin
                    state_d = EXPAND;
                    win_d = Key;
                    idx_d = 4'd2;
                end else if (state_q == LOADED && Stream_start) begin
                    state_d = STREAM;
                    rev_d = Stream_reverse;
                    idx_d = Stream_reverse ? LAST_IDX : 4'd0;
                end
            end
            EXPAND: begin
                win_d = {step_key, win_q[KEY_W-1:BLK_W]};
                idx_d = idx_q + 4'd1;
                state_d = (idx_q == LAST_IDX) ? LOADED : EXPAND;
            end
            STREAM: begin
                if (Rk_ready) begin
                    idx_d = rev_q ? idx_q - 4'd1 : idx_q + 4'd1;
                    state_d = Rk_last ? LOADED : STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q <= 4'd0;
            rev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            rev_q <= rev_d;
        end
    end
    always_ff @(posedge Clk) begin
        win_q <= win_d;
        if (key_hs) begin
            buf_q[0] <= Key[BLK_W-1:0];
            buf_q[1] <= Key[KEY_W-1:BLK_W];
        end else if (state_q == EXPAND) begin
            buf_q[idx_q] <= step_key;
        end
    end
endmodule

// File: tb/tb_aes256_key_schedule.sv
// tb_aes256_key_schedule: scoreboard bench for aes256_key_schedule against a word-level FIPS-197 model.
module tb_aes256_key_schedule;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic Key_valid = 1'b0;
    logic Stream_start = 1'b0;
    logic Stream_reverse = 1'b0;
    logic Rk_ready = 1'b1;
    logic [255:0] Key = '0;
    logic Key_ready, Expanded, Rk_valid, Rk_last;
    logic [127:0] Rk_data;
    logic [3:0] Rk_index;
    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int valid_cycles = 0;
    bit rand_ready = 1'b0;
    typedef struct packed {
        logic [127:0] data;
        logic [3:0] index;
        logic last;
    } rk_t;
    rk_t sbq[$];
    logic [127:0] exp_rk [15];
    logic [127:0] got [15];
    logic [7:0] sb [256];

    aes256_key_schedule dut (
        .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(Key_ready), .Key(Key),
        .Expanded(Expanded), .Stream_start(Stream_start), .Stream_reverse(Stream_reverse),
        .Rk_valid(Rk_valid), .Rk_ready(Rk_ready), .Rk_data(Rk_data), .Rk_index(Rk_index),
        .Rk_last(Rk_last)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v} << n;
        return d[15:8];
    endfunction

    // S(x) = affine(x^254) in GF(2^8)
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        repeat (254) y = gmul(y, x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Converts a FIPS-printed 128-bit value (byte 0 leftmost) to the bus byte order.
    function automatic logic [127:0] rev16(input logic [127:0] f);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b+:8] = f[127-8*b-:8];
        return r;
    endfunction

    // Textbook FIPS-197 expansion on big-endian words w[0..59].
    task automatic model(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 8; i++)
            w[i] = {key[32*i+:8], key[32*i+8+:8], key[32*i+16+:8], key[32*i+24+:8]};
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++)
            for (int b = 0; b < 16; b++)
                exp_rk[j][8*b+:8] = w[4*j+b/4][31-8*(b%4)-:8];
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_key_ready"}, Key_ready, 1);
        chk({tag, "_expanded"}, Expanded, 0);
        chk({tag, "_rk_valid"}, Rk_valid, 0);
        chk({tag, "_rk_last"}, Rk_last, 0);
        chk({tag, "_rk_index"}, Rk_index, 0);
    endtask

    task automatic load(input logic [255:0] k, input logic with_start);
        chk("key_ready_before_load", Key_ready, 1);
        Key_valid = 1'b1;
        Key = k;
        Stream_start = with_start;
        tick();
        Key_valid = 1'b0;
        Stream_start = 1'b0;
        model(k);
    endtask

    // Called one cycle after the key handshake; Stream_start pulses mid-expansion.
    task automatic wait_expanded;
        int n = 1;
        bit any_valid = 1'b0;
        while (!Expanded && n < 40) begin
            Stream_start = (n == 5);
            any_valid |= Rk_valid;
            tick();
            n++;
        end
        Stream_start = 1'b0;
        chk("expand_latency", n, 14);
        chk("no_stream_during_expand", any_valid, 0);
    endtask

    task automatic stream(input logic rev, input bit rnd);
        int n = 0;
        int hs0 = hs_count;
        int vc0 = valid_cycles;
        rand_ready = rnd;
        for (int k = 0; k < 15; k++) begin
            int i = rev ? 14 - k : k;
            sbq.push_back('{exp_rk[i], 4'(i), k == 14});
        end
        Stream_start = 1'b1;
        Stream_reverse = rev;
        tick();
        Stream_start = 1'b0;
        while ((sbq.size() != 0 || Rk_valid) && n < 500) begin
            tick();
            n++;
        end
        chk("stream_drained", sbq.size(), 0);
        chk("stream_handshakes", hs_count - hs0, 15);
        if (!rnd) chk("stream_cycles", valid_cycles - vc0, 15);
        chk("loaded_after_stream", {Expanded, Key_ready, Rk_valid}, 3'b110);
        rand_ready = 1'b0;
    endtask

    initial forever begin
        @(posedge Clk);
        #1;
        Rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        rk_t prev, e;
        bit stalled = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rk_valid) begin
                valid_cycles++;
                if (stalled) chk("hold_while_stalled", {Rk_data, Rk_index, Rk_last}, prev);
                if (Rk_ready) begin
                    hs_count++;
                    got[Rk_index] = Rk_data;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rk_unexpected: got index %0d, none expected", Rk_index);
                    end else begin
                        e = sbq.pop_front();
                        chk("rk_data", Rk_data, e.data);
                        chk("rk_index", Rk_index, e.index);
                        chk("rk_last", Rk_last, e.last);
                    end
                end
                stalled = !Rk_ready;
                prev = {Rk_data, Rk_index, Rk_last};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [255:0] c3;
        int n;
        for (int x = 0; x < 256; x++) sb[x] = sbox_ref(8'(x));
        for (int i = 0; i < 32; i++) c3[8*i+:8] = 8'(i);
        tick();
        chk_reset("reset");
        Rst = 1'b0;
        Stream_start = 1'b1;
        tick();
        Stream_start = 1'b0;
        tick();
        chk("start_in_idle_valid", Rk_valid, 0);
        chk("start_in_idle_ready", Key_ready, 1);

        load(c3, 1'b0);
        wait_expanded();
        stream(1'b0, 1'b0);
        chk("c3_rk0", got[0], rev16(128'h000102030405060708090a0b0c0d0e0f));
        chk("c3_rk1", got[1], rev16(128'h101112131415161718191a1b1c1d1e1f));
        chk("c3_rk2", got[2], rev16(128'ha573c29fa176c498a97fce93a572c09c));
        chk("c3_rk3", got[3], rev16(128'h1651a8cd0244beda1a5da4c10640bade));
        chk("c3_rk14", got[14], rev16(128'h24fc79ccbf0979e9371ac23c6d68de36));
        stream(1'b1, 1'b0);

        for (int t = 0; t < 3; t++) begin
            load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
            wait_expanded();
            stream(1'b0, 1'b1);
            stream(1'b1, 1'b1);
        end

        load('0, 1'b1);
        chk("key_wins_expanded", Expanded, 0);
        chk("key_wins_no_valid", Rk_valid, 0);
        wait_expanded();
        stream(1'b0, 1'b0);
        chk("zero_rk2", got[2], rev16(128'h62636363626363636263636362636363));

        load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (5) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk_reset("rst_expand");
        load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_expanded();
        stream(1'b0, 1'b1);

        for (int k = 0; k < 15; k++) sbq.push_back('{exp_rk[k], 4'(k), k == 14});
        Stream_start = 1'b1;
        Stream_reverse = 1'b0;
        tick();
        Stream_start = 1'b0;
        n = 0;
        while (!(Rk_valid && Rk_index == 4'd5) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_idx5", Rk_index, 5);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        sbq.delete();
        chk_reset("rst_stream");
        repeat (2) tick();
        chk("rst_stream_quiet", Rk_valid, 0);
        load({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_expanded();
        stream(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes256_key_schedule.md
Name: aes256_key_schedule

Overview:
- Sequential AES-256 key-schedule engine. Accepts one 256-bit cipher key and expands it into the 15 round keys, at one round key per cycle, into a local round-key buffer.
- Streams the stored round keys in forward order (encryption) or reverse order (decryption) over a valid/ready interface to the round datapath.
- Sits directly upstream of the AES-256 round pipeline and replaces the unrolled per-round expansion when an iterative core is built.

Parameters:
NUM_ROUNDS, 14, AES-256 round count; the buffer holds NUM_ROUNDS+1 keys. Fixed at 14; any other value is a compile-time error.

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst  input  1  synchronous, active-high reset
Key_valid  input  1  cipher key offered
Key_ready  output  1  engine can accept a key
Key  input  `AES256_KEY_LENGTH  cipher key; FIPS-197 byte 0 in bits [7:0]
Expanded  output  1  buffer holds a complete schedule for the last accepted key
Stream_start  input  1  single-cycle request to stream the schedule
Stream_reverse  input  1  sampled with Stream_start; 1 = order 14 down to 0
Rk_valid  output  1  round key presented
Rk_ready  input  1  consumer accepts the round key
Rk_data  output  `AES_BLOCK_SIZE  round key, same byte order as Key
Rk_index  output  4  round number of Rk_data (0..14)
Rk_last  output  1  final key of the current stream

Behaviour:
- All state updates occur on Clk rising edge. Rst is synchronous and active-high.
- Reset values: state IDLE; Key_ready=1; Expanded=0; Rk_valid=0; Rk_last=0; Rk_index=0. Buffer contents are don't-care.
- States: IDLE, EXPAND, LOADED, STREAM.
- IDLE:
  - Key_ready=1.
  - On Key_valid&&Key_ready: rk0 = Key words 1..4 (`AES_1ST_WORD..`AES_4TH_WORD); rk1 = words 5..8. Both are written to the buffer.
  - The 256-bit window is loaded with {rk1,rk0}, with rk0 in the 1st..4th word slots. Round counter r=2. Go to EXPAND.
- EXPAND:
  - Key_ready=0, Expanded=0.
  - Each cycle: rk[r] = step(window, r); write rk[r] to the buffer; window <= {rk[r], window upper half}; r <= r+1.
  - Step for even r: temp = SubWord(RotWord(word8)) ^ rcon(r/2), with RotWord = rotate right by 8 bits in this byte order and rcon(1)=`AES_RCON_01 .. rcon(7)=`AES_RCON_07.
  - Step for odd r: temp = SubWord(word8), no rotation, no rcon.
  - Output words: o1 = w1^temp, o2 = w2^o1, o3 = w3^o2, o4 = w4^o3.
  - After rk14 is written (13 EXPAND cycles), go to LOADED. Expanded=1 from the next cycle.
  - Latency: key handshake in cycle N gives Expanded=1 in cycle N+14.
  - Stream_start is ignored in EXPAND.
- LOADED:
  - Key_ready=1, Expanded=1.
  - Key handshake: go to EXPAND with the new key. Expanded=0 the next cycle. The old schedule is lost.
  - Stream_start (no key handshake in the same cycle): idx = Stream_reverse ? 14 : 0. Go to STREAM.
  - Key_valid and Stream_start together: the key wins and the start is dropped.
- STREAM:
  - Key_ready=0. Rk_valid=1. Rk_data=buf[idx]. Rk_index=idx.
  - Rk_last=1 when idx==14 in forward order, or idx==0 in reverse order.
  - On Rk_valid&&Rk_ready: idx steps by +1 (forward) or -1 (reverse).
  - On the last handshake: return to LOADED. Rk_valid=0 the next cycle.
  - While Rk_valid&&!Rk_ready: Rk_data, Rk_index and Rk_last stay stable.
  - Stream_start while in STREAM is ignored. Streams may be repeated any number of times from LOADED.
- Rk_valid must not depend combinationally on Rk_ready. A back-to-back stream with Rk_ready held at 1 takes exactly 15 cycles.
- Rst asserted in any state, including mid-EXPAND or mid-STREAM, returns the engine to the reset values on the next cycle. No partial key is ever presented after reset.
- Buffer: 15 x 128-bit registers. The write port is used only in IDLE/EXPAND; the read port only in STREAM.

Decomposition:
- Shared defines header (already in use) supplies `AES256_KEY_LENGTH, `AES_BLOCK_SIZE, `AES_WORD_SIZE, the word-slice macros and `AES_RCON_01..07.
- New in the shared package: enum key_sched_state_t {IDLE, EXPAND, LOADED, STREAM}, and the constant AES256_NUM_ROUND_KEYS=15.
- Sub-module aes256_key_expansion_step: combinational, runtime round input.
  - Ports: Input_key[255:0], Round[3:0], Output_key[127:0].
  - Contains 4 aes_sbox instances and selects the even/odd path from Round[0].

Test Plan:
- FIPS-197 C.3 key 000102..1f, forward stream, Rk_ready=1 -> Expanded rises 14 cycles after the key handshake.
  - rk0=000102030405060708090a0b0c0d0e0f, rk1=101112131415161718191a1b1c1d1e1f.
  - rk2=a573c29fa176c498a97fce93a572c09c, rk3=1651a8cd0244beda1a5da4c10640bade.
  - rk14=24fc79ccbf0979e9371ac23c6d68de36 with Rk_last=1 on that key only.
- Same key, Stream_reverse=1 -> Rk_index 14..0; first key 24fc79cc..de36, last key 000102..0f with Rk_last=1.
- Random Rk_ready backpressure during a forward stream -> Rk_data and Rk_index are held while stalled; exactly 15 handshakes; returns to LOADED.
- Key_valid and Stream_start asserted together in LOADED with a new key of all zeros -> no stream starts; Expanded drops; then rk2=62636363626363636263636362636363.
- Rst pulsed mid-EXPAND (r=7) and again mid-STREAM (idx=5) -> next cycle Key_ready=1, Expanded=0, Rk_valid=0; a fresh key gives a correct schedule.
- Stream_start asserted in IDLE and in EXPAND -> ignored, Rk_valid stays 0.
